// File: rtl/i2c_frame_writer_if.sv
// Stream bundle between the frame FIFO, the frame writer and i2c_master.
// "slave" is the frame writer's view; "master" is the surrounding environment.
interface i2c_frame_writer_if;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic       s_axis_tuser;

    logic [6:0] m_axis_cmd_address;
    logic       m_axis_cmd_start;
    logic       m_axis_cmd_read;
    logic       m_axis_cmd_write;
    logic       m_axis_cmd_write_multiple;
    logic       m_axis_cmd_stop;
    logic       m_axis_cmd_valid;
    logic       m_axis_cmd_ready;

    logic [7:0] m_axis_data_tdata;
    logic       m_axis_data_tvalid;
    logic       m_axis_data_tready;
    logic       m_axis_data_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  m_axis_cmd_ready, m_axis_data_tready,
        output s_axis_tready,
        output m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
        output m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_cmd_valid,
        output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output m_axis_cmd_ready, m_axis_data_tready,
        input  s_axis_tready,
        input  m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
        input  m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_cmd_valid,
        input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast
    );
endinterface

// File: rtl/i2c_frame_writer.sv
// Turns each byte frame (address header + payload) into one i2c_master
// write_multiple+stop command followed by a pass-through payload stream.
//
// state     | meaning
// IDLE      | waiting for a header byte
// CMD       | command presented to i2c_master, waiting for cmd_ready
// DATA      | payload passed through byte by byte
// DROP_REST | discarding the rest of a bad or truncated frame
module i2c_frame_writer #(
    parameter int MAX_LEN   = 255,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_frame_writer_if.slave    bus,
    output logic                 busy,
    output logic                 status_frame_done,
    output logic [LEN_WIDTH-1:0] status_frame_len,
    output logic                 status_dropped,
    output logic                 status_truncated
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, DROP_REST} state_t;

    localparam logic [LEN_WIDTH-1:0] LAST_IDX = LEN_WIDTH'(MAX_LEN - 1);
    localparam logic [LEN_WIDTH-1:0] MAX_VAL  = LEN_WIDTH'(MAX_LEN);

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] count, count_nxt;
    logic [6:0]           address, address_nxt;
    logic                 drop_report, drop_report_nxt;
    logic                 done_nxt, dropped_nxt, trunc_nxt;
    logic [LEN_WIDTH-1:0] len_nxt;
    logic                 at_max;

    // State, counter and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            count             <= '0;
            address           <= '0;
            drop_report       <= 1'b0;
            status_frame_done <= 1'b0;
            status_dropped    <= 1'b0;
            status_truncated  <= 1'b0;
            status_frame_len  <= '0;
        end else begin
            state             <= state_nxt;
            count             <= count_nxt;
            address           <= address_nxt;
            drop_report       <= drop_report_nxt;
            status_frame_done <= done_nxt;
            status_dropped    <= dropped_nxt;
            status_truncated  <= trunc_nxt;
            status_frame_len  <= len_nxt;
        end
    end

    // Next-state logic and stream handshakes; DATA is a zero-latency pass-through.
    always_comb begin
        state_nxt              = state;
        count_nxt              = count;
        address_nxt            = address;
        drop_report_nxt        = drop_report;
        done_nxt               = 1'b0;
        dropped_nxt            = 1'b0;
        trunc_nxt              = 1'b0;
        len_nxt                = status_frame_len;
        bus.s_axis_tready      = 1'b0;
        bus.m_axis_cmd_valid   = 1'b0;
        bus.m_axis_data_tvalid = 1'b0;
        bus.m_axis_data_tlast  = 1'b0;
        at_max                 = (count == LAST_IDX);
        case (state)
            IDLE: begin
                // tready must stay low while reset is held, even though the state reads IDLE
                bus.s_axis_tready = !rst;
                if (bus.s_axis_tvalid && !rst) begin
                    address_nxt = bus.s_axis_tdata[6:0];
                    if (bus.s_axis_tlast) begin
                        dropped_nxt = 1'b1;
                    end else if (bus.s_axis_tuser) begin
                        drop_report_nxt = 1'b1;
                        state_nxt       = DROP_REST;
                    end else begin
                        state_nxt = CMD;
                    end
                end
            end
            CMD: begin
                bus.m_axis_cmd_valid = 1'b1;
                if (bus.m_axis_cmd_ready) begin
                    state_nxt = DATA;
                    count_nxt = '0;
                end
            end
            DATA: begin
                bus.m_axis_data_tvalid = bus.s_axis_tvalid;
                bus.s_axis_tready      = bus.m_axis_data_tready;
                bus.m_axis_data_tlast  = bus.s_axis_tlast | at_max;
                if (bus.s_axis_tvalid && bus.m_axis_data_tready) begin
                    count_nxt = count + 1'b1;
                    if (bus.s_axis_tlast) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        len_nxt   = count + 1'b1;
                    end else if (at_max) begin
                        state_nxt       = DROP_REST;
                        trunc_nxt       = 1'b1;
                        len_nxt         = MAX_VAL;
                        drop_report_nxt = 1'b0;
                    end
                end
            end
            DROP_REST: begin
                bus.s_axis_tready = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) begin
                    state_nxt   = IDLE;
                    dropped_nxt = drop_report;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.m_axis_cmd_address        = address;
    assign bus.m_axis_cmd_start          = 1'b0;
    assign bus.m_axis_cmd_read           = 1'b0;
    assign bus.m_axis_cmd_write          = 1'b0;
    assign bus.m_axis_cmd_write_multiple = bus.m_axis_cmd_valid;
    assign bus.m_axis_cmd_stop           = bus.m_axis_cmd_valid;
    assign bus.m_axis_data_tdata         = bus.s_axis_tdata;
    assign busy                          = (state != IDLE);
endmodule

// File: tb/tb_i2c_frame_writer.sv
// Bench for i2c_frame_writer: frames go in, a frame-level reference model predicts
// commands, payload beats and status events, and observed streams are compared.
module tb_i2c_frame_writer;
    localparam int MAX_LEN   = 20;
    localparam int LEN_WIDTH = 8;

    typedef logic [7:0] bq_t[$];

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 busy;
    logic                 status_frame_done;
    logic [LEN_WIDTH-1:0] status_frame_len;
    logic                 status_dropped;
    logic                 status_truncated;

    i2c_frame_writer_if bus ();

    i2c_frame_writer #(.MAX_LEN(MAX_LEN), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus.slave),
        .busy              (busy),
        .status_frame_done (status_frame_done),
        .status_frame_len  (status_frame_len),
        .status_dropped    (status_dropped),
        .status_truncated  (status_truncated)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit throttle  = 1'b0;
    bit sink_rand = 1'b0;
    bit cmd_hold  = 1'b0;

    logic [15:0] got_cmd[$], exp_cmd[$];
    logic [15:0] got_data[$], exp_data[$];
    logic [15:0] got_stat[$], exp_stat[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream sink: command/data ready, optionally randomly throttled.
    initial begin
        bus.m_axis_cmd_ready   = 1'b0;
        bus.m_axis_data_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sink_rand) begin
                bus.m_axis_cmd_ready   = ($urandom_range(0, 3) != 0) && !cmd_hold;
                bus.m_axis_data_tready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.m_axis_cmd_ready   = !cmd_hold;
                bus.m_axis_data_tready = 1'b1;
            end
        end
    end

    // Monitor: record handshakes and status pulses mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_axis_cmd_valid && bus.m_axis_cmd_ready)
                got_cmd.push_back({4'd0, bus.m_axis_cmd_start, bus.m_axis_cmd_read,
                                   bus.m_axis_cmd_write, bus.m_axis_cmd_write_multiple,
                                   bus.m_axis_cmd_stop, bus.m_axis_cmd_address});
            if (bus.m_axis_data_tvalid && bus.m_axis_data_tready)
                got_data.push_back({7'd0, bus.m_axis_data_tlast, bus.m_axis_data_tdata});
            if (status_frame_done) got_stat.push_back({6'd0, 2'd1, status_frame_len});
            if (status_truncated)  got_stat.push_back({6'd0, 2'd2, status_frame_len});
            if (status_dropped)    got_stat.push_back({6'd0, 2'd3, 8'd0});
        end
    end

    // Frame-level reference: what one frame should produce downstream.
    task automatic model(input logic [7:0] hdr, input logic user, input bq_t p);
        int m;
        if (user || p.size() == 0) begin
            exp_stat.push_back({6'd0, 2'd3, 8'd0});
            return;
        end
        exp_cmd.push_back({4'd0, 5'b00011, hdr[6:0]});
        m = (p.size() > MAX_LEN) ? MAX_LEN : p.size();
        for (int i = 0; i < m; i++) exp_data.push_back({7'd0, (i == m - 1), p[i]});
        if (p.size() > MAX_LEN) exp_stat.push_back({6'd0, 2'd2, 8'(MAX_LEN)});
        else                    exp_stat.push_back({6'd0, 2'd1, 8'(p.size())});
    endtask

    task automatic put_beat(input logic [7:0] d, input logic last, input logic user);
        int   n;
        logic ok;
        if (throttle) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.s_axis_tdata  = d;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = last;
        bus.s_axis_tuser  = user;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (bus.s_axis_tready) ok = 1'b1;
            n++;
        end
        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL beat_accept observed=stalled expected=accepted_within_500_cycles");
        end
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic user, input bq_t p);
        model(hdr, user, p);
        put_beat(hdr, p.size() == 0, user);
        foreach (p[i]) put_beat(p[i], i == p.size() - 1, 1'($urandom_range(0, 1)));
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_ncmd"}, got_cmd.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++)
            check({tag, "_cmd"}, got_cmd[i], exp_cmd[i]);
        check({tag, "_ndata"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
            check({tag, "_data"}, got_data[i], exp_data[i]);
        check({tag, "_nstat"}, got_stat.size(), exp_stat.size());
        for (int i = 0; i < exp_stat.size() && i < got_stat.size(); i++)
            check({tag, "_stat"}, got_stat[i], exp_stat[i]);
        got_cmd.delete();  exp_cmd.delete();
        got_data.delete(); exp_data.delete();
        got_stat.delete(); exp_stat.delete();
    endtask

    initial begin
        bq_t       p;
        logic [6:0] addr0;

        // Reset state, with a valid beat offered to show tready stays low.
        bus.s_axis_tdata  = 8'h5a;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tready", bus.s_axis_tready, 0);
        check("rst_cmd_valid", bus.m_axis_cmd_valid, 0);
        check("rst_data_valid", bus.m_axis_data_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_len", status_frame_len, 0);
        check("rst_addr", bus.m_axis_cmd_address, 0);
        check("rst_pulses", {status_frame_done, status_dropped, status_truncated}, 0);
        bus.s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame.
        p = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h50, 1'b0, p);
        settle();
        check("basic_len", status_frame_len, 3);
        compare_queues("basic");

        // Command held off: no payload may pass, command fields stay put.
        cmd_hold = 1'b1;
        @(posedge clk);
        #1;
        p = '{8'ha1, 8'ha2};
        model(8'hba, 1'b0, p);
        put_beat(8'hba, 1'b0, 1'b0);
        bus.s_axis_tdata  = p[0];
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = 1'b0;
        @(negedge clk);
        addr0 = bus.m_axis_cmd_address;
        check("hold_addr0", addr0, 7'h3a);
        repeat (10) begin
            @(negedge clk);
            check("hold_tready", bus.s_axis_tready, 0);
            check("hold_cmd_valid", bus.m_axis_cmd_valid, 1);
            check("hold_cmd_fields", {bus.m_axis_cmd_address, bus.m_axis_cmd_write_multiple,
                                      bus.m_axis_cmd_stop}, {addr0, 2'b11});
            check("hold_data_valid", bus.m_axis_data_tvalid, 0);
        end
        @(posedge clk);
        #1;
        cmd_hold = 1'b0;
        put_beat(p[0], 1'b0, 1'b0);
        put_beat(p[1], 1'b1, 1'b0);
        settle();
        compare_queues("hold");

        // Throttled 16-byte frame.
        throttle  = 1'b1;
        sink_rand = 1'b1;
        p.delete();
        for (int i = 0; i < 16; i++) p.push_back(8'($urandom));
        send_frame(8'h9c, 1'b0, p);
        settle();
        check("thr_len", status_frame_len, 16);
        compare_queues("throttle");

        // Truncation, then a normal frame behind it.
        p.delete();
        for (int i = 0; i < MAX_LEN + 2; i++) p.push_back(8'(i + 1));
        send_frame(8'h41, 1'b0, p);
        p = '{8'hde, 8'had};
        send_frame(8'h42, 1'b0, p);
        settle();
        compare_queues("trunc");

        // Bad header and header-only frame.
        p = '{8'h01, 8'h02};
        send_frame(8'h33, 1'b1, p);
        p.delete();
        send_frame(8'h20, 1'b0, p);
        settle();
        compare_queues("drop");

        // Random frames.
        for (int f = 0; f < 12; f++) begin
            p.delete();
            for (int i = 0; i < $urandom_range(0, MAX_LEN + 3); i++) p.push_back(8'($urandom));
            send_frame(8'($urandom), ($urandom_range(0, 5) == 0), p);
        end
        settle();
        compare_queues("random");

        // Reset in the middle of DATA.
        throttle  = 1'b0;
        sink_rand = 1'b0;
        @(posedge clk);
        #1;
        exp_cmd.push_back({4'd0, 5'b00011, 7'h44});
        put_beat(8'h44, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_data.push_back({7'd0, 1'b0, 8'(8'h70 + i)});
            put_beat(8'(8'h70 + i), 1'b0, 1'b0);
        end
        bus.s_axis_tdata  = 8'h7f;
        bus.s_axis_tvalid = 1'b1;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_data_valid", bus.m_axis_data_tvalid, 0);
        check("mid_rst_cmd_valid", bus.m_axis_cmd_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tready", bus.s_axis_tready, 0);
        bus.s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare_queues("midrst");
        p = '{8'h55, 8'h66};
        send_frame(8'h12, 1'b0, p);
        settle();
        check("post_rst_len", status_frame_len, 2);
        compare_queues("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end
endmodule
